// File: rtl/mips_pipe_pkg.sv
// Shared constants for the MIPS32 pipeline bookkeeping blocks.
package mips_pipe_pkg;

    // Architectural register-address width
    localparam int REG_ADDR_W = 5;

    // Stage indices within the tracked portion of the pipeline
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    // Register $zero: writes to it never need forwarding
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/dest_match_encoder.sv
// Compares one source register address against every tracked stage and
// reports whether any valid stage writes it, plus the youngest such stage.
module dest_match_encoder
    import mips_pipe_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH*ADDR_W-1:0] stage_addr,
    input  logic [DEPTH-1:0]        stage_valid,
    input  logic [ADDR_W-1:0]       src,
    output logic                    hit,
    output logic [SEL_W-1:0]        sel
);

    logic src_nonzero;

    assign src_nonzero = (src != ADDR_W'(REG_ZERO));

    // Scan oldest to youngest so the lowest matching index wins last
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (src_nonzero && stage_valid[k] &&
                (stage_addr[k*ADDR_W +: ADDR_W] == src)) begin
                hit = 1'b1;
                sel = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/dest_addr_pipe_tracker.sv
// Tracks destination register address and write-pending flag for each
// instruction from EX through WB, with hold/stall/flush, and tells the
// forwarding unit which stage holds the youngest pending write per source.
module dest_addr_pipe_tracker
    import mips_pipe_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = $clog2(DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      hold,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [ADDR_W-1:0]         dest_addr_in,
    input  logic                      dest_we_in,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    output logic [DEPTH*ADDR_W-1:0]   dest_addr_out,
    output logic [DEPTH-1:0]          dest_valid_out,
    output logic [NUM_SRC-1:0]        fwd_hit,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_stage
);

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic              valid_q [DEPTH];

    // Stage registers: hold freezes everything, flush kills the EX capture,
    // stall keeps EX and drops a bubble into MEM, older stages always shift
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k]  <= '0;
                valid_q[k] <= 1'b0;
            end
        end else if (!hold) begin
            if (flush) begin
                addr_q[STG_EX]  <= dest_addr_in;
                valid_q[STG_EX] <= 1'b0;
            end else if (!stall) begin
                addr_q[STG_EX]  <= dest_addr_in;
                valid_q[STG_EX] <= dest_we_in;
            end

            if (stall) begin
                addr_q[STG_MEM]  <= '0;
                valid_q[STG_MEM] <= 1'b0;
            end else begin
                addr_q[STG_MEM]  <= addr_q[STG_EX];
                valid_q[STG_MEM] <= valid_q[STG_EX];
            end

            for (int k = 2; k < DEPTH; k++) begin
                addr_q[k]  <= addr_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_pack
        assign dest_addr_out[k*ADDR_W +: ADDR_W] = addr_q[k];
        assign dest_valid_out[k]                 = valid_q[k];
    end

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_match
        dest_match_encoder #(
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_match (
            .stage_addr  (dest_addr_out),
            .stage_valid (dest_valid_out),
            .src         (src_addr[j*ADDR_W +: ADDR_W]),
            .hit         (fwd_hit[j]),
            .sel         (fwd_stage[j*SEL_W +: SEL_W])
        );
    end

endmodule

// File: tb/tb_dest_addr_pipe_tracker.sv
// Bench for dest_addr_pipe_tracker: directed scenarios followed by random
// traffic, compared against a list-of-instructions reference model.
module tb_dest_addr_pipe_tracker;

    localparam int AW = 5;
    localparam int D  = 3;
    localparam int NS = 2;
    localparam int SW = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            hold;
    logic            stall;
    logic            flush;
    logic [AW-1:0]   dest_addr_in;
    logic            dest_we_in;
    logic [NS*AW-1:0] src_addr;
    logic [D*AW-1:0] dest_addr_out;
    logic [D-1:0]    dest_valid_out;
    logic [NS-1:0]   fwd_hit;
    logic [NS*SW-1:0] fwd_stage;

    int tests  = 0;
    int failed = 0;

    // Reference: what each stage holds, index 0 = EX
    logic [AW-1:0] m_addr [D];
    logic          m_vld  [D];

    dest_addr_pipe_tracker #(
        .ADDR_W  (AW),
        .DEPTH   (D),
        .NUM_SRC (NS),
        .SEL_W   (SW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .hold           (hold),
        .stall          (stall),
        .flush          (flush),
        .dest_addr_in   (dest_addr_in),
        .dest_we_in     (dest_we_in),
        .src_addr       (src_addr),
        .dest_addr_out  (dest_addr_out),
        .dest_valid_out (dest_valid_out),
        .fwd_hit        (fwd_hit),
        .fwd_stage      (fwd_stage)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < D; k++) begin
            m_addr[k] = '0;
            m_vld[k]  = 1'b0;
        end
    endtask

    // Compare all outputs against the model for the current src_addr
    task automatic check_all(input string tag);
        logic [D*AW-1:0]  e_addr;
        logic [D-1:0]     e_vld;
        logic [NS-1:0]    e_hit;
        logic [NS*SW-1:0] e_stg;
        logic [AW-1:0]    s;
        e_addr = '0;
        e_vld  = '0;
        e_hit  = '0;
        e_stg  = '0;
        for (int k = 0; k < D; k++) begin
            e_addr[k*AW +: AW] = m_addr[k];
            e_vld[k]           = m_vld[k];
        end
        for (int j = 0; j < NS; j++) begin
            s = src_addr[j*AW +: AW];
            if (s != 0) begin
                for (int k = 0; k < D; k++) begin
                    if (!e_hit[j] && m_vld[k] && m_addr[k] == s) begin
                        e_hit[j]           = 1'b1;
                        e_stg[j*SW +: SW]  = SW'(k);
                    end
                end
            end
        end
        chk({tag, ".addr"},  32'(dest_addr_out),  32'(e_addr));
        chk({tag, ".valid"}, 32'(dest_valid_out), 32'(e_vld));
        chk({tag, ".hit"},   32'(fwd_hit),        32'(e_hit));
        chk({tag, ".stage"}, 32'(fwd_stage),      32'(e_stg));
    endtask

    // Drive one clock's worth of controls; model applies the same edge
    task automatic step(input logic h, input logic s, input logic f,
                        input logic [AW-1:0] a, input logic w);
        logic [AW-1:0] na [D];
        logic          nv [D];
        hold = h; stall = s; flush = f; dest_addr_in = a; dest_we_in = w;
        @(posedge clock);
        if (!h) begin
            for (int k = 0; k < D; k++) begin
                na[k] = m_addr[k];
                nv[k] = m_vld[k];
            end
            if (f) begin
                na[0] = a; nv[0] = 1'b0;
            end else if (!s) begin
                na[0] = a; nv[0] = w;
            end
            if (s) begin
                na[1] = '0; nv[1] = 1'b0;
            end else begin
                na[1] = m_addr[0]; nv[1] = m_vld[0];
            end
            for (int k = 2; k < D; k++) begin
                na[k] = m_addr[k-1]; nv[k] = m_vld[k-1];
            end
            for (int k = 0; k < D; k++) begin
                m_addr[k] = na[k];
                m_vld[k]  = nv[k];
            end
        end
        @(negedge clock);
        hold = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic set_src(input logic [AW-1:0] s0, input logic [AW-1:0] s1);
        src_addr = {s1, s0};
        #1;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; stall = 1'b0; flush = 1'b0;
        dest_addr_in = '0; dest_we_in = 1'b0; src_addr = '0;
        model_clear();
        #1;
        check_all("reset");
        chk("reset.hit_const", 32'(fwd_hit), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Shift latency of a single write to r7
        set_src(5'd7, 5'd0);
        step(0, 0, 0, 5'd7, 1'b1);
        #1; chk("lat.e1", 32'(dest_valid_out), 32'b001); check_all("lat1");
        step(0, 0, 0, 5'd0, 1'b0);
        #1; chk("lat.e2", 32'(dest_valid_out), 32'b010); check_all("lat2");
        step(0, 0, 0, 5'd0, 1'b0);
        #1; chk("lat.e3", 32'(dest_valid_out), 32'b100);
        chk("lat.e3_stage", 32'(fwd_stage[SW-1:0]), 32'd2); check_all("lat3");
        step(0, 0, 0, 5'd0, 1'b0);
        #1; chk("lat.e4", 32'(dest_valid_out), 32'b000); check_all("lat4");

        // Youngest match wins, then older match after EX/MEM invalidated
        step(0, 0, 0, 5'd5, 1'b1);
        step(0, 0, 0, 5'd5, 1'b1);
        step(0, 0, 0, 5'd5, 1'b1);
        set_src(5'd5, 5'd0);
        chk("young.hit", 32'(fwd_hit), 32'b01);
        chk("young.stage0", 32'(fwd_stage[SW-1:0]), 32'd0);
        check_all("young");
        step(0, 1, 1, 5'd3, 1'b1);
        #1;
        chk("young.inv_stage", 32'(fwd_stage[SW-1:0]), 32'd2);
        chk("flushstall.v01", 32'(dest_valid_out[1:0]), 32'b00);
        check_all("young_inv");

        // $zero never matches, we=0 never matches
        step(0, 0, 0, 5'd0, 1'b1);
        step(0, 0, 0, 5'd12, 1'b0);
        set_src(5'd0, 5'd12);
        chk("zero.hit", 32'(fwd_hit), 32'b00);
        check_all("zero");

        // Stall: EX held, bubble into MEM, WB receives old MEM
        step(0, 0, 0, 5'd6, 1'b1);
        step(0, 0, 0, 5'd4, 1'b1);
        step(0, 1, 0, 5'd11, 1'b1);
        set_src(5'd4, 5'd6);
        chk("stall.addr", 32'(dest_addr_out), 32'({5'd6, 5'd0, 5'd4}));
        chk("stall.valid", 32'(dest_valid_out), 32'b101);
        check_all("stall");

        // Hold beats flush, then flush alone
        step(0, 0, 0, 5'd5, 1'b1);
        step(0, 0, 0, 5'd4, 1'b1);
        step(0, 0, 0, 5'd3, 1'b1);
        step(1, 0, 1, 5'd9, 1'b1);
        set_src(5'd3, 5'd5);
        chk("hold.addr", 32'(dest_addr_out), 32'({5'd5, 5'd4, 5'd3}));
        chk("hold.valid", 32'(dest_valid_out), 32'b111);
        check_all("hold");
        step(0, 0, 1, 5'd9, 1'b1);
        set_src(5'd9, 5'd3);
        chk("flush.addr", 32'(dest_addr_out), 32'({5'd4, 5'd3, 5'd9}));
        chk("flush.valid", 32'(dest_valid_out), 32'b110);
        check_all("flush");

        // Asynchronous reset between edges
        step(0, 0, 0, 5'd8, 1'b1);
        step(0, 0, 0, 5'd9, 1'b1);
        step(0, 0, 0, 5'd10, 1'b1);
        set_src(5'd8, 5'd10);
        chk("pre_rst.valid", 32'(dest_valid_out), 32'b111);
        #1 reset = 1'b1;
        #1;
        model_clear();
        chk("rst_mid.valid", 32'(dest_valid_out), 32'b000);
        chk("rst_mid.addr", 32'(dest_addr_out), 32'd0);
        chk("rst_mid.hit", 32'(fwd_hit), 32'b00);
        check_all("rst_mid");
        @(negedge clock);
        reset = 1'b0;

        // Random traffic with small register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            logic h, s, f;
            h = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 6) == 0);
            f = ($urandom_range(0, 6) == 0);
            step(h, s, f, AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            set_src(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
